// File: rtl/load_value_predictor.sv
// Load value predictor for the MEM stage: a PC-indexed last-value table plus an in-order queue
// of outstanding predictions. Define LVP_STRIDE_EN to add a per-entry stride to each prediction.
module load_value_predictor #(
  parameter int unsigned ENTRIES     = 64,
  parameter int unsigned CONF_BITS   = 2,
  parameter int unsigned CONF_THRESH = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           lookup_valid,
  input  logic [ADDR_WIDTH-1:0]          lookup_pc,
  output logic                           lookup_ready,
  output logic                           pred_valid,
  output logic                           pred_use,
  output logic [DATA_WIDTH-1:0]          pred_data,
  input  logic                           resolve_valid,
  input  logic [DATA_WIDTH-1:0]          resolve_data,
  input  logic                           flush,
  output logic                           correct,
  output logic                           mispredict,
  output logic [ADDR_WIDTH-1:0]          recover_pc,
  output logic [$clog2(DEPTH+1)-1:0]     outstanding
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
  localparam logic [CONF_BITS-1:0] CONF_MIN_USE = CONF_BITS'(CONF_THRESH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  use_pred;
    logic [DATA_WIDTH-1:0] pred;
  } q_entry_t;

  // Prediction table
  logic                  tbl_valid [ENTRIES];
  logic [ADDR_WIDTH-1:0] tbl_tag   [ENTRIES];
  logic [DATA_WIDTH-1:0] tbl_last  [ENTRIES];
  logic [CONF_BITS-1:0]  tbl_conf  [ENTRIES];
`ifdef LVP_STRIDE_EN
  logic [DATA_WIDTH-1:0] tbl_stride [ENTRIES];
`endif

  // Outstanding-prediction queue
  q_entry_t         q_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [IDX_W-1:0]      lk_idx;
  logic                  lk_hit;
  logic                  lk_use;
  logic [DATA_WIDTH-1:0] lk_pred;
  logic                  lk_fire;

  q_entry_t              head;
  logic [IDX_W-1:0]      rs_idx;
  logic                  rs_fire;
  logic                  rs_hit;
  logic                  rs_match;
  logic                  mispredict_now;
  logic                  correct_now;

  logic [CONF_BITS-1:0]  tr_conf;
  logic [DATA_WIDTH-1:0] tr_last;
`ifdef LVP_STRIDE_EN
  logic [DATA_WIDTH-1:0] tr_stride;
  logic [DATA_WIDTH-1:0] tr_delta;
`endif

  assign lookup_ready = (count != CNT_W'(DEPTH));
  assign outstanding  = count;

  // Lookup reads the table as registered, so a same-cycle resolve is not visible here
  always_comb begin
    lk_idx = lookup_pc[IDX_W+1:2];
    lk_hit = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lookup_pc);
    lk_use = lk_hit && (tbl_conf[lk_idx] >= CONF_MIN_USE);
`ifdef LVP_STRIDE_EN
    lk_pred = tbl_last[lk_idx] + tbl_stride[lk_idx];
`else
    lk_pred = tbl_last[lk_idx];
`endif
  end

  // Resolve checks the queue head against the returned value
  always_comb begin
    head           = q_mem[rd_ptr];
    rs_idx         = head.pc[IDX_W+1:2];
    rs_fire        = resolve_valid && (count != '0) && !flush;
    rs_hit         = tbl_valid[rs_idx] && (tbl_tag[rs_idx] == head.pc);
    rs_match       = (resolve_data == head.pred);
    mispredict_now = rs_fire && head.use_pred && !rs_match;
    correct_now    = rs_fire && head.use_pred && rs_match;
    lk_fire        = lookup_valid && lookup_ready && !flush && !mispredict_now;
  end

  // Training values for a tag-hit resolve
  always_comb begin
    tr_conf = '0;
    tr_last = resolve_data;
`ifdef LVP_STRIDE_EN
    tr_delta  = resolve_data - tbl_last[rs_idx];
    tr_stride = tbl_stride[rs_idx];
    if (tr_delta == tbl_stride[rs_idx]) begin
      tr_conf = (tbl_conf[rs_idx] == CONF_MAX) ? CONF_MAX : tbl_conf[rs_idx] + CONF_BITS'(1);
    end else begin
      tr_stride = tr_delta;
    end
`else
    if (resolve_data == tbl_last[rs_idx]) begin
      tr_conf = (tbl_conf[rs_idx] == CONF_MAX) ? CONF_MAX : tbl_conf[rs_idx] + CONF_BITS'(1);
    end
`endif
  end

  // Table update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_tag[i]   <= '0;
        tbl_last[i]  <= '0;
        tbl_conf[i]  <= '0;
`ifdef LVP_STRIDE_EN
        tbl_stride[i] <= '0;
`endif
      end
    end else if (rs_fire) begin
      tbl_valid[rs_idx] <= 1'b1;
      tbl_tag[rs_idx]   <= head.pc;
      tbl_last[rs_idx]  <= resolve_data;
      if (rs_hit) begin
        tbl_conf[rs_idx] <= tr_conf;
        tbl_last[rs_idx] <= tr_last;
`ifdef LVP_STRIDE_EN
        tbl_stride[rs_idx] <= tr_stride;
`endif
      end else begin
        tbl_conf[rs_idx] <= '0;
`ifdef LVP_STRIDE_EN
        tbl_stride[rs_idx] <= '0;
`endif
      end
    end
  end

  // Queue payload storage
  always_ff @(posedge clk) begin
    if (lk_fire) begin
      q_mem[wr_ptr] <= '{pc: lookup_pc, use_pred: lk_use, pred: lk_pred};
    end
  end

  // Queue pointers; flush and mispredict both squash everything outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush || mispredict_now) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (lk_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rs_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(lk_fire) - CNT_W'(rs_fire);
    end
  end

  // Registered responses and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_use   <= 1'b0;
      pred_data  <= '0;
      correct    <= 1'b0;
      mispredict <= 1'b0;
      recover_pc <= '0;
    end else begin
      pred_valid <= lk_fire;
      pred_use   <= lk_fire && lk_use;
      pred_data  <= (lk_fire && lk_use) ? lk_pred : '0;
      correct    <= correct_now;
      mispredict <= mispredict_now;
      recover_pc <= mispredict_now ? head.pc : '0;
    end
  end

endmodule

// File: tb/tb_load_value_predictor.sv
// Scoreboard bench for load_value_predictor: drivers queue expected responses, a negedge
// monitor pops and compares whenever the DUT presents a prediction or a pulse.
module tb_load_value_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        pred_valid;
  logic        pred_use;
  logic [31:0] pred_data;
  logic        resolve_valid;
  logic [31:0] resolve_data;
  logic        flush;
  logic        correct;
  logic        mispredict;
  logic [31:0] recover_pc;
  logic [2:0]  outstanding;

  load_value_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_use(pred_use), .pred_data(pred_data),
    .resolve_valid(resolve_valid), .resolve_data(resolve_data), .flush(flush),
    .correct(correct), .mispredict(mispredict), .recover_pc(recover_pc),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct { logic use_p; logic [31:0] data; } pred_exp_t;
  typedef struct { logic is_mis; logic [31:0] pc; } pulse_exp_t;

  pred_exp_t  pred_q[$];
  pulse_exp_t pulse_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic lv, input logic [31:0] lpc, input logic rv,
                      input logic [31:0] rdat, input logic fl);
    @(negedge clk);
    lookup_valid  = lv;
    lookup_pc     = lpc;
    resolve_valid = rv;
    resolve_data  = rdat;
    flush         = fl;
    @(posedge clk);
    #1;
    lookup_valid  = 1'b0;
    resolve_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp_use, input logic [31:0] exp_data);
    pred_exp_t e;
    e.use_p = exp_use;
    e.data  = exp_data;
    pred_q.push_back(e);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0);
  endtask

  // kind: 0 = no pulse, 1 = correct, 2 = mispredict
  task automatic resolve(input logic [31:0] d, input int kind, input logic [31:0] pc);
    pulse_exp_t e;
    if (kind != 0) begin
      e.is_mis = (kind == 2);
      e.pc     = pc;
      pulse_q.push_back(e);
    end
    step(1'b0, 32'h0, 1'b1, d, 1'b0);
  endtask

  // Monitor
  always @(negedge clk) begin
    pred_exp_t  pe;
    pulse_exp_t ue;
    if (rst_n) begin
      if (pred_valid) begin
        if (pred_q.size() == 0) check("unexpected_pred_valid", 32'(pred_valid), 32'h0);
        else begin
          pe = pred_q.pop_front();
          check("pred_use", 32'(pred_use), 32'(pe.use_p));
          check("pred_data", pred_data, pe.data);
        end
      end
      if (correct || mispredict) begin
        if (pulse_q.size() == 0) check("unexpected_pulse", {30'h0, mispredict, correct}, 32'h0);
        else begin
          ue = pulse_q.pop_front();
          check("mispredict", 32'(mispredict), 32'(ue.is_mis));
          check("correct", 32'(correct), 32'(!ue.is_mis));
          if (ue.is_mis) check("recover_pc", recover_pc, ue.pc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0;
    resolve_valid = 1'b0; resolve_data = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pred_valid", 32'(pred_valid), 32'h0);
    check("rst_pred_use", 32'(pred_use), 32'h0);
    check("rst_pred_data", pred_data, 32'h0);
    check("rst_pulses", {30'h0, mispredict, correct}, 32'h0);
    check("rst_recover_pc", recover_pc, 32'h0);
    check("rst_outstanding", 32'(outstanding), 32'h0);
    check("rst_ready", 32'(lookup_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: cold miss then allocate
    lookup(32'h400, 1'b0, 32'h0);
    check("t1_outstanding", 32'(outstanding), 32'h1);
    resolve(32'h55, 0, 32'h0);
    check("t1_drained", 32'(outstanding), 32'h0);

    // 2: train to confidence, then correct predictions; conf must saturate, not wrap
    lookup(32'h400, 1'b0, 32'h0);  resolve(32'h55, 0, 32'h0);
    lookup(32'h400, 1'b0, 32'h0);  resolve(32'h55, 0, 32'h0);
    lookup(32'h400, 1'b1, 32'h55); resolve(32'h55, 1, 32'h400);
    lookup(32'h400, 1'b1, 32'h55); resolve(32'h55, 1, 32'h400);
    lookup(32'h400, 1'b1, 32'h55); resolve(32'h55, 1, 32'h400);

    // 3: mispredict squashes younger entries and drops the same-cycle lookup
    lookup(32'h400, 1'b1, 32'h55);
    lookup(32'h404, 1'b0, 32'h0);
    lookup(32'h408, 1'b0, 32'h0);
    check("t3_outstanding", 32'(outstanding), 32'h3);
    begin
      pulse_exp_t e;
      e.is_mis = 1'b1;
      e.pc     = 32'h400;
      pulse_q.push_back(e);
    end
    step(1'b1, 32'h500, 1'b1, 32'h66, 1'b0);
    check("t3_squash", 32'(outstanding), 32'h0);
    lookup(32'h400, 1'b0, 32'h0);
    resolve(32'h66, 0, 32'h0);

    // 4: full queue, no bypass on simultaneous pop, pointer wrap
    lookup(32'h2010, 1'b0, 32'h0);
    lookup(32'h2014, 1'b0, 32'h0);
    lookup(32'h2018, 1'b0, 32'h0);
    lookup(32'h201C, 1'b0, 32'h0);
    check("t4_full_cnt", 32'(outstanding), 32'h4);
    check("t4_full_ready", 32'(lookup_ready), 32'h0);
    step(1'b1, 32'h2020, 1'b1, 32'h1, 1'b0);
    check("t4_pop_cnt", 32'(outstanding), 32'h3);
    check("t4_ready_after", 32'(lookup_ready), 32'h1);
    resolve(32'h2, 0, 32'h0);
    resolve(32'h3, 0, 32'h0);
    resolve(32'h4, 0, 32'h0);
    check("t4_drained", 32'(outstanding), 32'h0);
    for (int i = 0; i < 10; i++) begin
      lookup(32'h3040 + 32'(4 * i), 1'b0, 32'h0);
      resolve(32'(i), 0, 32'h0);
    end
    check("t4_wrap_cnt", 32'(outstanding), 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h99, 1'b0);
    check("t4_empty_resolve", 32'(outstanding), 32'h0);

    // 5: flush beats resolve and lookup; table retained
`ifdef LVP_STRIDE_EN
    lookup(32'h400, 1'b0, 32'h0);  resolve(32'h66, 0, 32'h0);
`endif
    lookup(32'h400, 1'b0, 32'h0);  resolve(32'h66, 0, 32'h0);
    lookup(32'h400, 1'b1, 32'h66); resolve(32'h66, 1, 32'h400);
    lookup(32'h400, 1'b1, 32'h66);
    check("t5_queued", 32'(outstanding), 32'h1);
    step(1'b1, 32'h400, 1'b1, 32'h77, 1'b1);
    check("t5_flushed", 32'(outstanding), 32'h0);
    lookup(32'h400, 1'b1, 32'h66);
    resolve(32'h66, 1, 32'h400);

`ifdef LVP_STRIDE_EN
    // 6: stride prediction, including wrap past 2^32
    lookup(32'h800, 1'b0, 32'h0);  resolve(32'h10, 0, 32'h0);
    lookup(32'h800, 1'b0, 32'h0);  resolve(32'h14, 0, 32'h0);
    lookup(32'h800, 1'b0, 32'h0);  resolve(32'h18, 0, 32'h0);
    lookup(32'h800, 1'b0, 32'h0);  resolve(32'h1C, 0, 32'h0);
    lookup(32'h800, 1'b1, 32'h20); resolve(32'h20, 1, 32'h800);
    lookup(32'h904, 1'b0, 32'h0);  resolve(32'hFFFFFFF0, 0, 32'h0);
    lookup(32'h904, 1'b0, 32'h0);  resolve(32'hFFFFFFF4, 0, 32'h0);
    lookup(32'h904, 1'b0, 32'h0);  resolve(32'hFFFFFFF8, 0, 32'h0);
    lookup(32'h904, 1'b0, 32'h0);  resolve(32'hFFFFFFFC, 0, 32'h0);
    lookup(32'h904, 1'b1, 32'h0);  resolve(32'h0, 1, 32'h904);
`endif

    repeat (3) @(negedge clk);
    check("pred_q_empty", 32'(pred_q.size()), 32'h0);
    check("pulse_q_empty", 32'(pulse_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
